// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and FSM state encoding for the bubble-sort sequencer.
package sort_pkg;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int N = 2 ** DEF_ADDR_WIDTH;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t ISSUE = 3'd1;
    localparam state_t WAIT  = 3'd2;
    localparam state_t NEXT  = 3'd3;
    localparam state_t DONE  = 3'd4;
endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// bubble_sort_ctrl_if: request side and CAS handshake of the bubble-sort sequencer.
interface bubble_sort_ctrl_if
    import sort_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  sort_start;
    logic                  cas_finish;
    logic                  cas_we;
    logic                  cas_start;
    logic [ADDR_WIDTH:0]   cas_i;
    logic                  busy;
    logic                  sort_done;
    logic [ADDR_WIDTH:0]   pass_count;
    modport master (
        input  sort_start, cas_finish, cas_we,
        output cas_start, cas_i, busy, sort_done, pass_count
    );
    modport slave (
        output sort_start, cas_finish, cas_we,
        input  cas_start, cas_i, busy, sort_done, pass_count
    );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: sequences compare-and-swap ops over an N-entry memory as a bubble sort
// with early exit on a swap-free pass.
module bubble_sort_ctrl
    import sort_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    bubble_sort_ctrl_if.master  bus
);
    localparam int W = ADDR_WIDTH + 1;
    localparam logic [W-1:0] LAST = W'(2 ** ADDR_WIDTH - 2);

    state_t         state, state_n;
    logic [W-1:0]   cas_i, cas_i_n;
    logic [W-1:0]   limit, limit_n;
    logic [W-1:0]   pass_count, pass_count_n;
    logic           swapped, swapped_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cas_i      <= '0;
            limit      <= '0;
            pass_count <= '0;
            swapped    <= 1'b0;
        end else begin
            state      <= state_n;
            cas_i      <= cas_i_n;
            limit      <= limit_n;
            pass_count <= pass_count_n;
            swapped    <= swapped_n;
        end
    end

    always_comb begin
        state_n      = state;
        cas_i_n      = cas_i;
        limit_n      = limit;
        pass_count_n = pass_count;
        swapped_n    = swapped;
        case (state)
            IDLE: if (bus.sort_start) begin
                cas_i_n      = '0;
                limit_n      = LAST;
                swapped_n    = 1'b0;
                pass_count_n = W'(1);
                state_n      = ISSUE;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                // the write-enable seen in the finish cycle still marks a swap
                swapped_n = swapped | bus.cas_we;
                state_n   = bus.cas_finish ? NEXT : WAIT;
            end
            NEXT: if (cas_i < limit) begin
                cas_i_n = cas_i + 1'b1;
                state_n = ISSUE;
            end else if (!swapped || limit == '0) begin
                state_n = DONE;
            end else begin
                limit_n      = limit - 1'b1;
                cas_i_n      = '0;
                swapped_n    = 1'b0;
                pass_count_n = pass_count + 1'b1;
                state_n      = ISSUE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.cas_start  = state == ISSUE;
        bus.busy       = state != IDLE;
        bus.sort_done  = state == DONE;
        bus.cas_i      = cas_i;
        bus.pass_count = pass_count;
    end
endmodule
